aes_dec_top: RTL and testbench
==============================

AES_DEC_TOP -- requirements
Module: aes_dec_top

Interface
REQ-001 SHALL have no parameters; the block is fixed AES-128 (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled on a rising edge only in IDLE or DONE.
REQ-005 cipher_text  input  128  ciphertext block, FIPS-197 byte order (bits [127:120] = byte 0); sampled with start.
REQ-006 cipher_key  input  128  AES-128 cipher key K0, same byte order; sampled with start.
REQ-007 done  output  1  level; result valid.
REQ-008 completed_round  output  10  thermometer progress of decryption rounds 1..10.
REQ-009 plain_text  output  128  registered decrypted block.

Function
REQ-010 SHALL implement the FSM states IDLE, KEYEXP, INIT, ROUND and DONE, with exactly one state transition per clock.
REQ-011 IDLE/DONE, start=1: latch cipher_text into the state register and cipher_key into the key register, clear completed_round to 0, deassert done, go to KEYEXP with counter=1.
REQ-012 start SHALL be ignored in KEYEXP, INIT and ROUND; the latched inputs SHALL NOT change during an operation.
REQ-013 KEYEXP SHALL be 10 cycles of forward key expansion; on edge i (i=1..10) the key register becomes Ki using Rcon 01,02,04,08,10,20,40,80,1b,36; after edge 10 the FSM goes to INIT.
REQ-014 INIT SHALL be 1 cycle: state <= state XOR K10; key <= K9 (inverse schedule); counter=1; go to ROUND.
REQ-015 Inverse schedule from Ki to K(i-1), with words w0..w3:
- w3' = w3^w2
- w2' = w2^w1
- w1' = w1^w0
- w0' = w0^SubWord(RotWord(w3'))^Rcon_i
REQ-016 ROUND r=1..9 SHALL compute state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR K(10-r)) and step the key register to K(9-r).
REQ-017 ROUND r=10 SHALL omit InvMixColumns: plain_text <= InvSubBytes(InvShiftRows(state)) XOR K0.
REQ-018 On the edge completing round r, completed_round[r-1] SHALL be set; lower bits SHALL stay set.
REQ-019 After round 10: done <= 1, FSM goes to DONE, and completed_round equals 10'h3FF.
REQ-020 Latency: done SHALL rise on the 21st rising edge after the edge that accepted start (10 KEYEXP + 1 INIT + 10 ROUND).
REQ-021 DONE: done, plain_text and completed_round SHALL hold until the next accepted start.
REQ-022 With start held high continuously, a new operation SHALL begin on the first edge in DONE; done is then high for exactly one cycle.
REQ-023 plain_text SHALL change only on the round-10 edge, reset or never otherwise; it SHALL NOT be cleared by start.
REQ-024 InvSubBytes SHALL be the exact FIPS-197 inverse S-box.
REQ-025 SubWord SHALL be the FIPS-197 forward S-box.
REQ-026 InvMixColumns SHALL multiply each column by {0e,0b,0d,09} over GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-027 InvShiftRows SHALL cyclically shift row n right by n bytes.
REQ-028 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-029 rstn=0 SHALL immediately, regardless of clk, set: FSM=IDLE, counter=0, done=0, completed_round=0, plain_text=0, state and key registers=0.
REQ-030 Reset asserted mid-operation SHALL abort it; no partial result appears; after release the block waits in IDLE for start.
REQ-031 Reset release SHALL take effect on the next rising edge; start sampled on that edge SHALL be accepted.

Verification
REQ-032 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff, done high 21 edges after start.
REQ-033 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32 -> plain_text 3243f6a8885a308d313198a2e0370734; check completed_round after each edge: 0 (KEYEXP/INIT), 001, 003, ... 3FF.
REQ-034 Pulse start at round 5, with different inputs applied -> ignored; the C.1 result is unchanged and on schedule.
REQ-035 Assert rstn low asynchronously at round 4, then restart with B vectors -> all outputs 0 during reset; correct B result 21 edges after the new start.
REQ-036 Hold start high across two back-to-back C.1 operations -> done high for 1 cycle between runs; second result identical; completed_round clears on the restarting edge.
REQ-037 Randomised loop of 1000 key/ciphertext pairs checked against the software AES inverse reference model -> zero mismatches.

Source files
------------

// File: rtl/aes_dec_top.sv
// AES-128 iterative decryptor: on-the-fly key expansion to K10,
// then ten inverse rounds stepping the key schedule backwards.
module aes_dec_top (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] cipher_key,
    output logic         done,
    output logic [9:0]   completed_round,
    output logic [127:0] plain_text
);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        INIT,
        ROUND,
        DONE
    } fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] key;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Field inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = ginv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
                 ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
          ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // Byte k of the column-major state sits at bits [127-8k -: 8].
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic         mix);
        logic [15:0][7:0] b;
        logic [127:0]     t;
        logic [7:0]       a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[4*c+r] = isbox(s[127-8*(4*((c-r)&3)+r) -: 8])
                         ^ k[127-8*(4*c+r) -: 8];
            end
        end
        t = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[4*c];
            a1 = b[4*c+1];
            a2 = b[4*c+2];
            a3 = b[4*c+3];
            if (mix) begin
                t[127-8*(4*c)   -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                                      ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                t[127-8*(4*c+1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                                      ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                t[127-8*(4*c+2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                                      ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                t[127-8*(4*c+3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                                      ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end else begin
                t[127-8*(4*c)   -: 8] = a0;
                t[127-8*(4*c+1) -: 8] = a1;
                t[127-8*(4*c+2) -: 8] = a2;
                t[127-8*(4*c+3) -: 8] = a3;
            end
        end
        return t;
    endfunction

    // Control FSM with datapath registers; one transition per clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm             <= IDLE;
            cnt             <= '0;
            st              <= '0;
            key             <= '0;
            done            <= 1'b0;
            completed_round <= '0;
            plain_text      <= '0;
        end else begin
            unique case (fsm)
                IDLE, DONE: begin
                    if (start) begin
                        st              <= cipher_text;
                        key             <= cipher_key;
                        completed_round <= '0;
                        done            <= 1'b0;
                        cnt             <= 4'd1;
                        fsm             <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key <= key_fwd(key, rcon(cnt));
                    if (cnt == 4'd10) fsm <= INIT;
                    else cnt <= cnt + 4'd1;
                end
                INIT: begin
                    st  <= st ^ key;
                    key <= key_inv(key, rcon(4'd10));
                    cnt <= 4'd1;
                    fsm <= ROUND;
                end
                ROUND: begin
                    completed_round <= {completed_round[8:0], 1'b1};
                    if (cnt == 4'd10) begin
                        plain_text <= inv_round(st, key, 1'b0);
                        done       <= 1'b1;
                        fsm        <= DONE;
                    end else begin
                        st  <= inv_round(st, key, 1'b1);
                        key <= key_inv(key, rcon(4'd10 - cnt));
                        cnt <= cnt + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_top.sv
// Bench for aes_dec_top: FIPS-197 vectors, protocol corner cases
// and random blocks against a table-driven software decryptor.
module tb_aes_dec_top;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] cipher_key;
    logic         done;
    logic [9:0]   completed_round;
    logic [127:0] plain_text;

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         edges = 0;
    logic       done_q = 1'b0;
    logic [7:0] sb[256];
    logic [7:0] isb[256];

    aes_dec_top dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .cipher_text     (cipher_text),
        .cipher_key      (cipher_key),
        .done            (done),
        .completed_round (completed_round),
        .plain_text      (plain_text)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a,
                                       input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward box from brute-force inverse plus affine map.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_dec(input logic [127:0] key,
                                             input logic [127:0] ct);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]],
                       sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++)
            s[k] = ct[127-8*k -: 8] ^ w[40+k/4][31-8*(k%4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = isb[s[r+4*((c-r+4)%4)]]
                             ^ w[4*rnd+c][31-8*r -: 8];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd > 0) begin
                    s[4*c]   = mul(a0,14) ^ mul(a1,11) ^ mul(a2,13) ^ mul(a3,9);
                    s[4*c+1] = mul(a0,9)  ^ mul(a1,14) ^ mul(a2,11) ^ mul(a3,13);
                    s[4*c+2] = mul(a0,13) ^ mul(a1,9)  ^ mul(a2,14) ^ mul(a3,11);
                    s[4*c+3] = mul(a0,11) ^ mul(a1,13) ^ mul(a2,9)  ^ mul(a3,14);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
        end
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
        return out;
    endfunction

    // Monitor: every rising done pops one expectation (value and edge).
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got %h, expected none",
                         plain_text);
            end else begin
                mon_e = exp_q.pop_front();
                check("plain_text", plain_text, mon_e.pt);
                check("latency_edge", 128'(edges), 128'(mon_e.due));
            end
        end
        done_q = done;
    end

    task automatic issue(input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, output int acc);
        exp_t e;
        @(negedge clk);
        cipher_key  = k;
        cipher_text = ct;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = edges;
        e.pt  = pt;
        e.due = acc + 21;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending, expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_completed_round"}, 128'(completed_round), 128'(0));
        check({tag, "_plain_text"}, plain_text, 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        exp_t       e;
        logic [9:0] cr_exp;
        logic [10:0] t11;
        logic [127:0] k, ct;

        build_tables();
        rstn        = 1'b0;
        start       = 1'b0;
        cipher_text = '0;
        cipher_key  = '0;
        #2;
        check_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // C.1 vector
        issue(C1_K, C1_CT, C1_PT, acc);
        wait_empty(40);
        repeat (5) @(negedge clk);
        check("hold_done", 128'(done), 128'(1));
        check("hold_plain_text", plain_text, C1_PT);
        check("hold_completed_round", 128'(completed_round), 128'(10'h3ff));

        // Appendix B vector with per-edge progress
        issue(B_K, B_CT, B_PT, acc);
        check("progress_edge0", 128'(completed_round), 128'(0));
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            t11    = (11'd1 << ((n <= 11) ? 0 : n - 11)) - 11'd1;
            cr_exp = t11[9:0];
            check($sformatf("progress_edge%0d", n),
                  128'(completed_round), 128'(cr_exp));
        end
        wait_empty(5);

        // start pulse mid-operation is ignored
        issue(C1_K, C1_CT, C1_PT, acc);
        repeat (15) @(negedge clk);
        cipher_key  = {$urandom, $urandom, $urandom, $urandom};
        cipher_text = {$urandom, $urandom, $urandom, $urandom};
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(40);

        // asynchronous reset in round 4, then restart with B
        issue(C1_K, C1_CT, C1_PT, acc);
        repeat (14) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        check_zero("held_reset");
        rstn        = 1'b1;
        cipher_key  = B_K;
        cipher_text = B_CT;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.pt  = B_PT;
        e.due = edges + 21;
        exp_q.push_back(e);
        wait_empty(40);

        // back-to-back with start held high
        @(negedge clk);
        cipher_key  = C1_K;
        cipher_text = C1_CT;
        start       = 1'b1;
        @(negedge clk);
        acc   = edges;
        e.pt  = C1_PT;
        e.due = acc + 21;
        exp_q.push_back(e);
        e.due = acc + 43;
        exp_q.push_back(e);
        repeat (21) @(negedge clk);
        check("b2b_done_high", 128'(done), 128'(1));
        check("b2b_cr_full", 128'(completed_round), 128'(10'h3ff));
        @(negedge clk);
        check("b2b_done_one_cycle", 128'(done), 128'(0));
        check("b2b_cr_cleared", 128'(completed_round), 128'(0));
        start = 1'b0;
        wait_empty(40);

        // random blocks against the software model
        for (int i = 0; i < 1000; i++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            ct = {$urandom, $urandom, $urandom, $urandom};
            issue(k, ct, ref_dec(k, ct), acc);
            wait_empty(40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
